unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

Sequential arbiter that shares one downstream memory port between the instruction-fetch requester and the load/store requester of the out-of-order core. It sits between the core and a single unified memory or cache port. Each transaction is granted, its address, write data and mask are latched, and the downstream handshake is held until `mem_resp`. The response and read data are then routed back to the owning requester. Contention is resolved by round-robin, with an optional fixed data priority.

## Interface
- `FAIR`, default 1: 1 = round-robin on simultaneous requests; 0 = load/store always wins ties.
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `fetch_mem_read`  in  1  fetch read request; held high until `fetch_mem_resp`
- `fetch_mem_address`  in  32  fetch address
- `fetch_mem_rdata`  out  32  fetch read data; equals `mem_rdata` while `fetch_mem_resp`=1, else 0
- `fetch_mem_resp`  out  1  one-cycle completion pulse to fetch
- `ld_st_mem_read`  in  1  load request; held until `ld_st_mem_resp`
- `ld_st_mem_write`  in  1  store request; held until `ld_st_mem_resp`
- `ld_st_mem_address`  in  32  load/store address
- `ld_st_mem_wdata`  in  32  store data
- `ld_st_mem_wmask`  in  4  store byte enables
- `ld_st_mem_rdata`  out  32  load data; equals `mem_rdata` while `ld_st_mem_resp`=1, else 0
- `ld_st_mem_resp`  out  1  one-cycle completion pulse to load/store
- `mem_read`  out  1  downstream read strobe; registered
- `mem_write`  out  1  downstream write strobe; registered
- `mem_addr`  out  32  latched address
- `mem_wdata`  out  32  latched store data
- `mem_wmask`  out  4  latched byte enables; `4'hF` on reads
- `mem_rdata`  in  32  downstream read data
- `mem_resp`  in  1  downstream completion; valid only while `mem_read` or `mem_write` is high

## Operation
- States are IDLE, INST and DATA. A `last_grant` register holds FETCH or LDST; its reset value is FETCH.
- In IDLE:
  - Fetch request only: go to INST.
  - Load/store request only: go to DATA.
  - Both requesting: grant LDST if `FAIR`=0. If `FAIR`=1, grant the requester that is not `last_grant`.
- On entering INST or DATA:
  - Latch address, wdata and wmask.
  - Set `mem_read` or `mem_write`.
  - Update `last_grant`.
- Load/store with both read and write high is treated as a write.
- INST: hold `mem_read`=1. When `mem_resp`=1:
  - Assert `fetch_mem_resp` in the same cycle.
  - Pass `mem_rdata` through to `fetch_mem_rdata`.
  - Clear strobes at the edge and return to IDLE.
- DATA: same as INST, using `ld_st_mem_resp`. `mem_write` is held for stores instead of `mem_read`.
- Changes on requester inputs after the grant are ignored until the response, because all downstream values come from latched registers.
- `mem_resp` in IDLE is ignored, and no resp pulse is generated.
- Reset, asynchronous at any point including mid-transaction:
  - state returns to IDLE and `last_grant` to FETCH;
  - `mem_read`, `mem_write`, `mem_addr`, `mem_wdata`, `mem_wmask` all go to 0;
  - both resp outputs and both rdata outputs go to 0;
  - an in-flight downstream transaction is abandoned with no response generated.

## Timing
- Request sampled in IDLE at cycle t. Downstream strobe and latched address are valid from cycle t+1.
- `mem_resp` at cycle t+k (k≥1) gives requester resp at cycle t+k, combinationally. Minimum request-to-resp latency is 1 cycle after the grant edge.
- Strobes drop at the edge ending the resp cycle. There is exactly one IDLE cycle between back-to-back transactions.
- The requester must deassert its request in the cycle after resp. A request still high in IDLE is treated as a new request.
- Resp outputs are never high for more than one cycle per transaction. Fetch and load/store resp are never high together.

## Test plan
- Fetch alone, addr 0x0000_0060, `mem_resp` two cycles after the strobe with rdata 0x0051_3023 -> `mem_read`=1 and `mem_addr`=0x60 from t+1; `fetch_mem_resp` pulses for 1 cycle with rdata 0x0051_3023; `ld_st_mem_resp` stays 0.
- Store, addr 0x100, wdata 0xDEAD_BEEF, wmask 4'b0011 -> `mem_write`=1 with latched values; the requester changes wdata mid-transaction and `mem_wdata` stays 0xDEAD_BEEF; `ld_st_mem_resp` pulses once.
- Simultaneous fetch and load after reset, `FAIR`=1:
  - Load is granted first; fetch is granted in the IDLE cycle after the load resp.
  - Repeated ties then alternate FETCH, LDST, FETCH, …
- Same contention with `FAIR`=0 and the load request re-raised every time -> load is always granted; fetch waits.
- `rst` asserted while in DATA before `mem_resp` -> all outputs 0 immediately without a clock edge; a later `mem_resp` produces no requester resp; the next tie is granted to LDST.
- `mem_resp` pulsed in IDLE, and read plus write both high on load/store -> no resp is generated for the IDLE pulse; the dual request issues `mem_write` only.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Shares one downstream memory port between instruction fetch and load/store.
// One transaction at a time: grant, latch request, hold strobe until mem_resp, route the response back.
module unified_mem_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_mem_read,
  input  logic [31:0] fetch_mem_address,
  output logic [31:0] fetch_mem_rdata,
  output logic        fetch_mem_resp,
  input  logic        ld_st_mem_read,
  input  logic        ld_st_mem_write,
  input  logic [31:0] ld_st_mem_address,
  input  logic [31:0] ld_st_mem_wdata,
  input  logic [3:0]  ld_st_mem_wmask,
  output logic [31:0] ld_st_mem_rdata,
  output logic        ld_st_mem_resp,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  typedef enum logic [1:0] {IDLE, INST, DATA} state_t;
  typedef enum logic {GNT_FETCH, GNT_LDST} grant_t;

  state_t      state_q, state_d;
  grant_t      last_q, last_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;

  logic ls_req;
  logic grant_ls;
  logic grant_f;

  assign ls_req = ld_st_mem_read | ld_st_mem_write;
  // On a tie, fairness hands the port to whoever did not win last time.
  assign grant_ls = ls_req && (!fetch_mem_read || !FAIR || (last_q == GNT_FETCH));
  assign grant_f  = fetch_mem_read && !grant_ls;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    read_d  = read_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    case (state_q)
      IDLE: begin
        if (grant_f) begin
          state_d = INST;
          last_d  = GNT_FETCH;
          read_d  = 1'b1;
          write_d = 1'b0;
          addr_d  = fetch_mem_address;
          wdata_d = 32'h0;
          wmask_d = 4'hF;
        end else if (grant_ls) begin
          // A simultaneous read and write is issued as a store.
          state_d = DATA;
          last_d  = GNT_LDST;
          read_d  = !ld_st_mem_write;
          write_d = ld_st_mem_write;
          addr_d  = ld_st_mem_address;
          wdata_d = ld_st_mem_wdata;
          wmask_d = ld_st_mem_write ? ld_st_mem_wmask : 4'hF;
        end
      end
      INST, DATA: begin
        if (mem_resp) begin
          state_d = IDLE;
          read_d  = 1'b0;
          write_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= GNT_FETCH;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wmask_q <= 4'h0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      read_q  <= read_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  assign mem_read  = read_q;
  assign mem_write = write_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;

  // Responses are routed combinationally so the requester sees them in the mem_resp cycle.
  assign fetch_mem_resp  = (state_q == INST) && mem_resp;
  assign ld_st_mem_resp  = (state_q == DATA) && mem_resp;
  assign fetch_mem_rdata = fetch_mem_resp ? mem_rdata : 32'h0;
  assign ld_st_mem_rdata = ld_st_mem_resp ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: index 0 is a FAIR=1 instance, index 1 a FAIR=0 instance.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_rd    [2];
  logic [31:0] f_addr  [2];
  logic [31:0] f_rdata [2];
  logic        f_resp  [2];
  logic        l_rd    [2];
  logic        l_wr    [2];
  logic [31:0] l_addr  [2];
  logic [31:0] l_wdata [2];
  logic [3:0]  l_wmask [2];
  logic [31:0] l_rdata [2];
  logic        l_resp  [2];
  logic        m_rd    [2];
  logic        m_wr    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [3:0]  m_wmask [2];
  logic [31:0] m_rdata [2];
  logic        m_resp  [2];

  int mlast [2];
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.FAIR(1'b1)) u_fair (
    .clk(clk), .rst(rst),
    .fetch_mem_read(f_rd[0]), .fetch_mem_address(f_addr[0]),
    .fetch_mem_rdata(f_rdata[0]), .fetch_mem_resp(f_resp[0]),
    .ld_st_mem_read(l_rd[0]), .ld_st_mem_write(l_wr[0]),
    .ld_st_mem_address(l_addr[0]), .ld_st_mem_wdata(l_wdata[0]),
    .ld_st_mem_wmask(l_wmask[0]), .ld_st_mem_rdata(l_rdata[0]),
    .ld_st_mem_resp(l_resp[0]),
    .mem_read(m_rd[0]), .mem_write(m_wr[0]), .mem_addr(m_addr[0]),
    .mem_wdata(m_wdata[0]), .mem_wmask(m_wmask[0]),
    .mem_rdata(m_rdata[0]), .mem_resp(m_resp[0])
  );

  unified_mem_arbiter #(.FAIR(1'b0)) u_prio (
    .clk(clk), .rst(rst),
    .fetch_mem_read(f_rd[1]), .fetch_mem_address(f_addr[1]),
    .fetch_mem_rdata(f_rdata[1]), .fetch_mem_resp(f_resp[1]),
    .ld_st_mem_read(l_rd[1]), .ld_st_mem_write(l_wr[1]),
    .ld_st_mem_address(l_addr[1]), .ld_st_mem_wdata(l_wdata[1]),
    .ld_st_mem_wmask(l_wmask[1]), .ld_st_mem_rdata(l_rdata[1]),
    .ld_st_mem_resp(l_resp[1]),
    .mem_read(m_rd[1]), .mem_write(m_wr[1]), .mem_addr(m_addr[1]),
    .mem_wdata(m_wdata[1]), .mem_wmask(m_wmask[1]),
    .mem_rdata(m_rdata[1]), .mem_resp(m_resp[1])
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_quiet(input int d, input string tag);
    check_val({tag, "_mem_read"},  32'(m_rd[d]), 32'h0);
    check_val({tag, "_mem_write"}, 32'(m_wr[d]), 32'h0);
    check_val({tag, "_f_resp"},    32'(f_resp[d]), 32'h0);
    check_val({tag, "_l_resp"},    32'(l_resp[d]), 32'h0);
    check_val({tag, "_f_rdata"},   f_rdata[d], 32'h0);
    check_val({tag, "_l_rdata"},   l_rdata[d], 32'h0);
  endtask

  task automatic check_reset_outs(input int d, input string tag);
    check_quiet(d, tag);
    check_val({tag, "_mem_addr"},  m_addr[d], 32'h0);
    check_val({tag, "_mem_wdata"}, m_wdata[d], 32'h0);
    check_val({tag, "_mem_wmask"}, 32'(m_wmask[d]), 32'h0);
  endtask

  // Entered in an IDLE cycle just after a rising edge, with requests already driven.
  task automatic txn(input int d, input int lat, input logic [31:0] rd_val, output int win);
    logic        fr, lw;
    logic [31:0] ea, ew;
    logic [3:0]  em;
    fr = f_rd[d];
    lw = l_wr[d];
    if (!(l_rd[d] || l_wr[d])) win = 0;
    else if (!fr) win = 1;
    else if (d == 1) win = 1;
    else win = (mlast[d] == 0) ? 1 : 0;
    ea = (win == 0) ? f_addr[d] : l_addr[d];
    ew = l_wdata[d];
    em = (win == 1 && lw) ? l_wmask[d] : 4'hF;
    @(posedge clk); #1;
    mlast[d] = win;
    check_val("grant_mem_read",  32'(m_rd[d]), 32'(win == 0 || !lw));
    check_val("grant_mem_write", 32'(m_wr[d]), 32'(win == 1 && lw));
    check_val("grant_mem_addr",  m_addr[d], ea);
    check_val("grant_mem_wmask", 32'(m_wmask[d]), 32'(em));
    if (win == 1 && lw) check_val("grant_mem_wdata", m_wdata[d], ew);
    check_val("grant_no_f_resp", 32'(f_resp[d]), 32'h0);
    check_val("grant_no_l_resp", 32'(l_resp[d]), 32'h0);
    f_addr[d]  = $urandom;
    l_addr[d]  = $urandom;
    l_wdata[d] = $urandom;
    l_wmask[d] = 4'($urandom);
    repeat (lat - 1) begin
      @(posedge clk); #1;
      check_val("hold_mem_addr", m_addr[d], ea);
      check_val("hold_strobe", 32'(m_rd[d] | m_wr[d]), 32'h1);
      if (win == 1 && lw) check_val("hold_mem_wdata", m_wdata[d], ew);
    end
    m_rdata[d] = rd_val;
    m_resp[d]  = 1'b1;
    #1;
    check_val("resp_fetch",   32'(f_resp[d]), 32'(win == 0));
    check_val("resp_ldst",    32'(l_resp[d]), 32'(win == 1));
    check_val("rdata_fetch",  f_rdata[d], (win == 0) ? rd_val : 32'h0);
    check_val("rdata_ldst",   l_rdata[d], (win == 1) ? rd_val : 32'h0);
    @(posedge clk); #1;
    m_resp[d]  = 1'b0;
    m_rdata[d] = 32'h0;
    if (win == 0) f_rd[d] = 1'b0;
    else begin
      l_rd[d] = 1'b0;
      l_wr[d] = 1'b0;
    end
    #1;
    check_quiet(d, "after_resp");
  endtask

  task automatic idle_pulse(input int d);
    m_rdata[d] = $urandom;
    m_resp[d]  = 1'b1;
    #1;
    check_quiet(d, "idle_pulse");
    @(posedge clk); #1;
    m_resp[d] = 1'b0;
    check_quiet(d, "idle_after");
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check_reset_outs(d, "async_rst");
      mlast[d] = 0;
    end
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int w;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      f_rd[d] = 0; f_addr[d] = 0; l_rd[d] = 0; l_wr[d] = 0;
      l_addr[d] = 0; l_wdata[d] = 0; l_wmask[d] = 0;
      m_rdata[d] = 0; m_resp[d] = 0; mlast[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) check_reset_outs(d, "reset");
    rst = 1'b0;
    @(posedge clk); #2;

    // Fetch alone, response two cycles after the strobe appears.
    f_rd[0] = 1; f_addr[0] = 32'h0000_0060;
    txn(0, 3, 32'h0051_3023, w);

    // Store with mid-transaction wdata changes.
    l_wr[0] = 1; l_addr[0] = 32'h100; l_wdata[0] = 32'hDEAD_BEEF; l_wmask[0] = 4'b0011;
    txn(0, 3, 32'h1234_5678, w);

    // Ties after reset with fairness: LDST first, then alternating.
    async_reset();
    @(posedge clk); #2;
    for (int i = 0; i < 4; i++) begin
      f_rd[0] = 1; f_addr[0] = $urandom;
      l_rd[0] = 1; l_addr[0] = $urandom;
      txn(0, $urandom_range(1, 3), $urandom, w);
      txn(0, $urandom_range(1, 3), $urandom, w);
    end

    // Fixed priority: load re-raised every time keeps winning.
    f_rd[1] = 1; f_addr[1] = $urandom;
    for (int i = 0; i < 4; i++) begin
      l_rd[1] = 1; l_addr[1] = $urandom;
      txn(1, $urandom_range(1, 3), $urandom, w);
    end
    txn(1, 2, $urandom, w);

    // Reset while a load is outstanding.
    l_rd[0] = 1; l_addr[0] = 32'h0000_0ABC;
    @(posedge clk); #1;
    check_val("pre_rst_mem_read", 32'(m_rd[0]), 32'h1);
    check_val("pre_rst_mem_addr", m_addr[0], 32'h0000_0ABC);
    rst = 1'b1;
    #1;
    check_reset_outs(0, "mid_rst");
    m_rdata[0] = 32'hCAFE_F00D;
    m_resp[0]  = 1'b1;
    #1;
    check_reset_outs(0, "rst_late_resp");
    rst = 1'b0;
    mlast[0] = 0; mlast[1] = 0;
    #1;
    check_quiet(0, "post_rst_late_resp");
    l_rd[0] = 0;
    m_resp[0] = 0;
    @(posedge clk); #2;
    f_rd[0] = 1; f_addr[0] = $urandom;
    l_rd[0] = 1; l_addr[0] = $urandom;
    txn(0, 1, $urandom, w);
    txn(0, 1, $urandom, w);

    // mem_resp in IDLE, then read+write together.
    idle_pulse(0);
    l_rd[0] = 1; l_wr[0] = 1; l_addr[0] = $urandom; l_wdata[0] = $urandom; l_wmask[0] = 4'b1010;
    txn(0, 2, $urandom, w);

    // Randomized traffic on both instances.
    for (int d = 0; d < 2; d++) begin
      for (int it = 0; it < 150; it++) begin
        if (!f_rd[d] && $urandom_range(0, 1) == 1) begin
          f_rd[d] = 1; f_addr[d] = $urandom;
        end
        if (!l_rd[d] && !l_wr[d] && $urandom_range(0, 1) == 1) begin
          int k;
          k = $urandom_range(0, 2);
          l_rd[d] = (k != 1);
          l_wr[d] = (k != 0);
          l_addr[d] = $urandom; l_wdata[d] = $urandom; l_wmask[d] = 4'($urandom);
        end
        if (!f_rd[d] && !l_rd[d] && !l_wr[d]) idle_pulse(d);
        else txn(d, $urandom_range(1, 4), $urandom, w);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
